game_sound_mixer: RTL and testbench

//  N-channel event-triggered square-wave tone generator with arbitrated single-bit output.

---
 rtl/game_sound_mixer_pkg.sv | 21 ++
 rtl/game_sound_mixer_tone_channel.sv | 95 +++++++++
 rtl/game_sound_mixer.sv | 84 ++++++++
 tb/tb_game_sound_mixer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/game_sound_mixer_pkg.sv
// game_sound_pkg: shared constants for the game sound mixer.
//   MIX_PRIORITY / MIX_OR : values for the MIX_MODE parameter
//   MAX_CH                : largest supported channel count
//   *_HP / *_DUR          : default half-periods / durations (clk cycles @100 MHz)
//   sel_width()           : width of the winning-channel index (min 1)
package game_sound_pkg;
   localparam int MIX_PRIORITY = 0;
   localparam int MIX_OR       = 1;
   localparam int MAX_CH       = 8;

   localparam int BGM_HP   = 113636;    // ~440 Hz
   localparam int BGM_DUR  = 25000000;  // 250 ms
   localparam int FIRE_HP  = 50000;     // 1 kHz
   localparam int FIRE_DUR = 5000000;   // 50 ms
   localparam int HIT_HP   = 200000;    // 250 Hz
   localparam int HIT_DUR  = 15000000;  // 150 ms

   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/game_sound_mixer_tone_channel.sv
// sound_tone_channel: one event-triggered square-wave tone channel.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_trig         : trigger level; a rising edge (re)starts the tone
//   i_hp, i_dur    : half-period and duration, sampled on the starting edge
//   o_active       : channel playing
//   o_tone         : square-wave level, 0 while inactive
// Optional SOUND_DECAY_EN: the effective half-period doubles every
// 2^DECAY_SHIFT active cycles, saturating after three doublings.
module sound_tone_channel #(
   parameter int DIV_W       = 18,
   parameter int DUR_W       = 26,
   parameter int DECAY_SHIFT = 22
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_trig,
   input  logic [DIV_W-1:0] i_hp,
   input  logic [DUR_W-1:0] i_dur,
   output logic             o_active,
   output logic             o_tone
);
   localparam int EW = DIV_W + 3;   // room for hp << 3

   logic             r_trig_q;
   logic             r_active;
   logic             r_tone;
   logic [DIV_W-1:0] r_hp;
   logic [DUR_W-1:0] r_dur_cnt;
   logic [EW-1:0]    r_div_cnt;
   logic             w_start;
   logic [EW-1:0]    w_eff_hp;

   // A zero-duration edge is ignored entirely.
   assign w_start = i_trig & ~r_trig_q & (i_dur != '0);

`ifdef SOUND_DECAY_EN
   logic [1:0]             r_step;
   logic [DECAY_SHIFT-1:0] r_decay_cnt;

   assign w_eff_hp = {3'b000, r_hp} << r_step;

   always_ff @(posedge i_clk) begin
      if (i_reset || w_start) begin
         r_step      <= '0;
         r_decay_cnt <= '0;
      end else if (r_active) begin
         r_decay_cnt <= r_decay_cnt + 1'b1;
         if ((&r_decay_cnt) && (r_step != 2'd3))
            r_step <= r_step + 1'b1;
      end
   end
`else
   assign w_eff_hp = {3'b000, r_hp};
`endif

   always_ff @(posedge i_clk) begin
      // Edge history tracks trig even in reset, so a held level never fires.
      r_trig_q <= i_trig;
      if (i_reset) begin
         r_active  <= 1'b0;
         r_tone    <= 1'b0;
         r_hp      <= '0;
         r_dur_cnt <= '0;
         r_div_cnt <= '0;
      end else if (w_start) begin
         r_active  <= 1'b1;
         r_tone    <= 1'b0;
         r_hp      <= i_hp;
         r_dur_cnt <= i_dur;
         r_div_cnt <= '0;
      end else if (r_active) begin
         if (r_dur_cnt == DUR_W'(1)) begin
            r_active  <= 1'b0;
            r_tone    <= 1'b0;
            r_dur_cnt <= '0;
            r_div_cnt <= '0;
         end else begin
            r_dur_cnt <= r_dur_cnt - DUR_W'(1);
            if (w_eff_hp == '0) begin
               r_tone    <= 1'b0;
               r_div_cnt <= '0;
            end else if (r_div_cnt >= w_eff_hp - EW'(1)) begin
               // >= keeps div bounded if hp ever shrinks under it
               r_tone    <= ~r_tone;
               r_div_cnt <= '0;
            end else begin
               r_div_cnt <= r_div_cnt + EW'(1);
            end
         end
      end
   end

   assign o_active = r_active;
   assign o_tone   = r_tone;
endmodule

// File: rtl/game_sound_mixer.sv
// game_sound_mixer: N-channel triggered square-wave generator mixed onto one
// registered buzzer pin.
//   clk, reset        : clock, synchronous active-high reset
//   mute              : forces buzz low, channels keep running
//   trig              : per-channel trigger levels (rising edge starts tone)
//   half_period_flat  : ch i half-period at [i*DIV_W +: DIV_W]
//   duration_flat     : ch i duration at [i*DUR_W +: DUR_W]
//   buzz              : registered mixed tone
//   ch_active         : per-channel playing flags
//   sel_ch            : registered winning (highest active) channel, 0 if none
// Optional macro SOUND_DECAY_EN enables falling-pitch decay in every channel.
module game_sound_mixer
   import game_sound_pkg::*;
#(
   parameter  int CH_COUNT    = 4,
   parameter  int DIV_W       = 18,
   parameter  int DUR_W       = 26,
   parameter  int MIX_MODE    = MIX_PRIORITY,
   parameter  int DECAY_SHIFT = 22,
   localparam int SEL_W       = sel_width(CH_COUNT)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      mute,
   input  logic [CH_COUNT-1:0]       trig,
   input  logic [CH_COUNT*DIV_W-1:0] half_period_flat,
   input  logic [CH_COUNT*DUR_W-1:0] duration_flat,
   output logic                      buzz,
   output logic [CH_COUNT-1:0]       ch_active,
   output logic [SEL_W-1:0]          sel_ch
);
   logic [CH_COUNT-1:0] w_active;
   logic [CH_COUNT-1:0] w_tone;
   logic                w_any;
   logic [SEL_W-1:0]    w_win;
   logic                w_mixed;
   logic                r_buzz;
   logic [SEL_W-1:0]    r_sel;

   for (genvar g = 0; g < CH_COUNT; g++) begin : g_ch
      sound_tone_channel #(
         .DIV_W       (DIV_W),
         .DUR_W       (DUR_W),
         .DECAY_SHIFT (DECAY_SHIFT)
      ) u_ch (
         .i_clk    (clk),
         .i_reset  (reset),
         .i_trig   (trig[g]),
         .i_hp     (half_period_flat[g*DIV_W +: DIV_W]),
         .i_dur    (duration_flat[g*DUR_W +: DUR_W]),
         .o_active (w_active[g]),
         .o_tone   (w_tone[g])
      );
   end

   // Ascending scan: the last active hit is the highest index.
   always_comb begin
      w_any = 1'b0;
      w_win = '0;
      for (int i = 0; i < CH_COUNT; i++) begin
         if (w_active[i]) begin
            w_any = 1'b1;
            w_win = SEL_W'(i);
         end
      end
      // Inactive channels already drive tone 0, so OR needs no masking.
      if (MIX_MODE == MIX_OR) w_mixed = |w_tone;
      else                    w_mixed = w_any & w_tone[w_win];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_buzz <= 1'b0;
         r_sel  <= '0;
      end else begin
         r_buzz <= ~mute & w_mixed;
         r_sel  <= w_win;
      end
   end

   assign buzz      = r_buzz;
   assign sel_ch    = r_sel;
   assign ch_active = w_active;
endmodule

// File: tb/tb_game_sound_mixer.sv
module tb_game_sound_mixer;
   localparam int CH = 3;
   localparam int DW = 8;
   localparam int UW = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             mute;
   logic [CH-1:0]    trig;
   logic [CH*DW-1:0] hpf;
   logic [CH*UW-1:0] durf;
   logic             buzz0, buzz1;
   logic [CH-1:0]    act0, act1;
   logic [1:0]       sel0, sel1;

   int total = 0;
   int bad   = 0;

   // Reference model: per channel, cycles elapsed since start.
   bit m_act[CH];
   int m_n[CH];
   int m_hp[CH];
   int m_dur[CH];
   bit m_tq[CH];
   bit e_buzz0, e_buzz1;
   int e_sel;

   always #5 clk = ~clk;

   game_sound_mixer #(.CH_COUNT(CH), .DIV_W(DW), .DUR_W(UW), .MIX_MODE(0), .DECAY_SHIFT(4)) u_pri (
      .clk(clk), .reset(reset), .mute(mute), .trig(trig),
      .half_period_flat(hpf), .duration_flat(durf),
      .buzz(buzz0), .ch_active(act0), .sel_ch(sel0));

   game_sound_mixer #(.CH_COUNT(CH), .DIV_W(DW), .DUR_W(UW), .MIX_MODE(1), .DECAY_SHIFT(4)) u_or (
      .clk(clk), .reset(reset), .mute(mute), .trig(trig),
      .half_period_flat(hpf), .duration_flat(durf),
      .buzz(buzz1), .ch_active(act1), .sel_ch(sel1));

   // Square wave: level after n cycles is the parity of completed half-periods.
   function automatic bit m_tone(input int i);
      return m_act[i] && (m_hp[i] != 0) && (((m_n[i] / m_hp[i]) % 2) == 1);
   endfunction

   task automatic set_ch(input int i, input int hp, input int dur);
      hpf[i*DW +: DW]  = DW'(hp);
      durf[i*UW +: UW] = UW'(dur);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      int win;
      bit orr, pri, rise;
      logic [CH-1:0] ea;
      @(posedge clk);
      win = -1;
      orr = 1'b0;
      for (int i = 0; i < CH; i++) begin
         if (m_act[i]) win = i;
         orr |= m_tone(i);
      end
      pri = (win >= 0) ? m_tone(win) : 1'b0;
      if (reset) begin
         e_buzz0 = 1'b0; e_buzz1 = 1'b0; e_sel = 0;
      end else begin
         e_buzz0 = !mute && pri;
         e_buzz1 = !mute && orr;
         e_sel   = (win < 0) ? 0 : win;
      end
      for (int i = 0; i < CH; i++) begin
         rise     = trig[i] && !m_tq[i];
         m_tq[i]  = trig[i];
         if (reset) m_act[i] = 1'b0;
         else if (rise && durf[i*UW +: UW] != '0) begin
            m_act[i] = 1'b1;
            m_n[i]   = 0;
            m_hp[i]  = int'(hpf[i*DW +: DW]);
            m_dur[i] = int'(durf[i*UW +: UW]);
         end else if (m_act[i]) begin
            m_n[i]++;
            if (m_n[i] >= m_dur[i]) m_act[i] = 1'b0;
         end
      end
      #1;
      for (int i = 0; i < CH; i++) ea[i] = m_act[i];
      check("act_pri", 32'(act0), 32'(ea));
      check("act_or",  32'(act1), 32'(ea));
      check("buzz_pri", 32'(buzz0), 32'(e_buzz0));
      check("buzz_or",  32'(buzz1), 32'(e_buzz1));
      check("sel_pri", 32'(sel0), 32'(e_sel));
      check("sel_or",  32'(sel1), 32'(e_sel));
   endtask

   initial begin
      int ch;
      reset = 1'b1; mute = 1'b0; trig = 3'b001;
      hpf = '0; durf = '0;
      set_ch(0, 4, 40); set_ch(1, 6, 40); set_ch(2, 10, 40);
      for (int i = 0; i < CH; i++) begin
         m_act[i] = 1'b0; m_n[i] = 0; m_hp[i] = 0; m_dur[i] = 0; m_tq[i] = 1'b0;
      end
      repeat (3) step();
      check("reset_buzz", 32'(buzz0), 32'd0);
      check("reset_act",  32'(act0),  32'd0);
      reset = 1'b0;
      repeat (5) step();
      check("held_trig_idle", 32'(act0), 32'd0);

      // single ch0 pulse, hp=4 dur=40
      trig = 3'b000; step();
      trig = 3'b001; step();
      check("ch0_started", 32'(act0), 32'd1);
      trig = 3'b000; repeat (45) step();

      // ch0 playing, ch2 overrides at cycle 10
      trig[0] = 1'b1; step(); trig[0] = 1'b0; repeat (9) step();
      trig[2] = 1'b1; step(); trig[2] = 1'b0; repeat (60) step();

      // ch1 retriggered at cycle 20
      trig[1] = 1'b1; step(); trig[1] = 1'b0; repeat (19) step();
      trig[1] = 1'b1; step(); trig[1] = 1'b0; repeat (50) step();

      // ch0+ch1 together (OR mix), mute in the middle
      trig = 3'b011; step(); trig = 3'b000; repeat (10) step();
      mute = 1'b1; repeat (10) step();
      check("mute_keeps_active", 32'(act0), 32'd3);
      mute = 1'b0; repeat (25) step();

      // zero duration ignored
      set_ch(2, 10, 0); trig[2] = 1'b1; step(); trig[2] = 1'b0;
      check("dur0_idle", 32'(act0), 32'd0);
      repeat (5) step(); set_ch(2, 10, 40);

      // hp=0: active but silent
      set_ch(0, 0, 20); trig[0] = 1'b1; step(); trig[0] = 1'b0;
      repeat (22) step(); set_ch(0, 4, 40);

      // reset mid-play
      trig = 3'b111; step(); trig = 3'b000; repeat (7) step();
      reset = 1'b1; step();
      check("midreset_act", 32'(act0), 32'd0);
      reset = 1'b0; repeat (3) step();

      // randomized traffic
      repeat (600) begin
         if ($urandom_range(0, 7) == 0) begin
            ch = int'($urandom_range(0, CH-1));
            set_ch(ch, int'($urandom_range(0, 7)), int'($urandom_range(0, 30)));
         end
         for (int i = 0; i < CH; i++)
            if ($urandom_range(0, 9) == 0) trig[i] = ~trig[i];
         if ($urandom_range(0, 31) == 0) mute = ~mute;
         reset = ($urandom_range(0, 199) == 0);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
